instr_mem_port: RTL and testbench
=================================

# instr_mem_port

Instruction-side memory responder that serves the fetch stage's req/gnt/rvalid bus from a synchronous word-addressed instruction store. It sits directly upstream of `fetch` and answers `instr_req_o`/`instr_addr_o` with `instr_gnt_i`, `instr_rvalid_i`, `instr_rdata_i` and `instr_err_i`. Grant wait states, response latency and the outstanding-request limit are configurable, so fetch stalls and back-to-back traffic can be exercised. A program-load write port fills the store before or between runs.

## Interface
- `MEM_DEPTH`, 4096: number of 32-bit words; power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; `MEM_DEPTH*4`-aligned.
- `GNT_WAIT`, 0: cycles `req` must be held before `gnt`; range 0..7.
- `RESP_LAT`, 1: cycles from the grant cycle to `rvalid`; range 1..4.
- `MAX_OUTSTANDING`, 2: maximum granted requests not yet answered; range 1..4.
- `clk` in 1: the single clock, rising edge.
- `rstn` in 1: reset. Reset is asynchronous and active-low.
- `instr_req_i` in 1: request from fetch.
- `instr_addr_i` in 32: byte address. Bits [1:0] are ignored; the containing word is returned.
- `instr_gnt_o` out 1: request accepted this cycle.
- `instr_rvalid_o` out 1: response valid this cycle.
- `instr_rdata_o` out 32: response word.
- `instr_err_o` out 1: response error. Qualified by `instr_rvalid_o`.
- `prog_we_i` in 1: program-load write strobe.
- `prog_addr_i` in 32: byte address of the write; bits [1:0] are ignored.
- `prog_wdata_i` in 32: write data.

## Operation
- Address decode:
  - A byte address is in range iff `BASE_ADDR <= addr < BASE_ADDR + 4*MEM_DEPTH`.
  - Word index = `(addr - BASE_ADDR) >> 2`, truncated to `log2(MEM_DEPTH)` bits.
- Grant FSM has three states: IDLE, WAIT, READY.
  - IDLE: if `req` and `GNT_WAIT==0`, go to READY behaviour in the same cycle. If `req` and `GNT_WAIT>0`, load the wait counter with `GNT_WAIT-1` and go to WAIT.
  - WAIT: decrement the counter while `req` is high. At 0, go to READY. If `req` drops, go to IDLE.
  - READY: `gnt = req & can_accept & ~prog_we_i`. On a grant with `GNT_WAIT>0`, return to IDLE. With `GNT_WAIT==0`, stay in READY. If `req` drops, go to IDLE.
- `can_accept = (outstanding < MAX_OUTSTANDING) | instr_rvalid_o`. A response retiring this cycle frees a slot for a same-cycle grant.
- Outstanding counter: +1 on grant, −1 when `instr_rvalid_o` is high. Both in the same cycle leave it unchanged. Width is 3 bits.
- Response pipeline:
  - On grant, the store is read synchronously. Stage 1 captures {valid, err, data}. Data is the word if the address is in range; otherwise data is 0 and err is 1.
  - Stages shift every cycle, with no backpressure. The last stage drives the outputs.
- Program load:
  - `prog_we_i` writes the word in the cycle it is asserted; out-of-range writes are ignored.
  - Any grant is suppressed in that cycle (single port). The FSM state and wait counter hold.
- A read granted in the cycle after a write to the same index returns the new data.
- Memory contents are not reset.

## Timing
- Reset values: `instr_gnt_o`=0, `instr_rvalid_o`=0, `instr_rdata_o`=0, `instr_err_o`=0. FSM=IDLE, outstanding=0, all pipeline valids=0.
- `instr_gnt_o` is combinational from `req`, the FSM state, the counter and `prog_we_i`.
  - With `GNT_WAIT=0`, grant happens in the same cycle as `req`.
  - Otherwise the earliest grant is in cycle `GNT_WAIT` after `req` rises (req in cycle 0, gnt in cycle N).
- `instr_rvalid_o` asserts exactly `RESP_LAT` cycles after the grant cycle, for one cycle per grant. Responses are in grant order.
- Sustained throughput:
  - 1 grant/cycle when `GNT_WAIT=0` and `MAX_OUTSTANDING >= RESP_LAT`.
  - Otherwise grants stall while outstanding equals `MAX_OUTSTANDING` and no retire occurs.
- Reset asserted mid-operation clears all in-flight responses immediately. No response is emitted after `rstn` rises for a request granted before reset.
- `instr_rdata_o` and `instr_err_o` hold their last value while `rvalid` is low.

## Test plan
- Reset, then `GNT_WAIT=0`, `RESP_LAT=1`. Preload word 0=32'h0000_0013 and word 1=32'h0040_0093. Req addr 0 then addr 4 on consecutive cycles -> gnt in both cycles; rvalid in cycles 1 and 2 with rdata 32'h0000_0013 then 32'h0040_0093; err=0.
- `GNT_WAIT=2`. Req held from cycle 0 -> gnt first in cycle 2; rvalid in cycle 3. Drop req in cycle 1 and re-raise in cycle 2 -> wait restarts and gnt comes in cycle 4.
- `RESP_LAT=3`, `MAX_OUTSTANDING=2`, req held continuously -> gnt in cycles 0 and 1, none in 2, then gnt again in cycle 3 (same-cycle retire). Outstanding never exceeds 2.
- `MEM_DEPTH=16`, `BASE_ADDR=0`. Req addr 32'h40 -> rvalid with err=1 and rdata=0. Addr 32'h3E -> word 15, err=0.
- `prog_we_i` asserted in the same cycle as req to word 3 -> no gnt that cycle. The next cycle's gnt returns the newly written data.
- `RESP_LAT=2`: grant in cycle 0, assert `rstn=0` in cycle 1 -> rvalid stays 0 through and after reset; outstanding=0 after release.

Source files
------------

// File: rtl/instr_mem_port.sv
// Instruction-side memory responder: req/gnt/rvalid fetch port over a word-addressed store,
// with configurable grant wait states, response latency and outstanding limit.
//
// state   | meaning
// S_IDLE  | no request being served; starts wait or grants directly
// S_WAIT  | counting down grant wait states while req is held
// S_READY | grant allowed when a slot is free and no program write
module instr_mem_port #(
    parameter int          MEM_DEPTH       = 4096,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          GNT_WAIT        = 0,
    parameter int          RESP_LAT        = 1,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        prog_we_i,
    input  logic [31:0] prog_addr_i,
    input  logic [31:0] prog_wdata_i
);

    localparam int          AW      = $clog2(MEM_DEPTH);
    localparam logic [32:0] SPAN    = 33'(MEM_DEPTH) << 2;
    localparam logic [2:0]  MAX_OUT = 3'(MAX_OUTSTANDING);
    localparam logic [2:0]  GW_M1   = 3'(GNT_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_READY
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  outstanding;
    logic        gnt;
    logic        can_accept;

    logic [31:0] mem [MEM_DEPTH];

    // 33-bit difference: bit 32 flags an address below BASE_ADDR
    logic [32:0] rd_diff, wr_diff;
    logic        rd_in_range, wr_in_range;
    logic [AW-1:0] rd_idx, wr_idx;

    assign rd_diff     = {1'b0, instr_addr_i} - {1'b0, BASE_ADDR};
    assign wr_diff     = {1'b0, prog_addr_i} - {1'b0, BASE_ADDR};
    assign rd_in_range = ~rd_diff[32] & ({1'b0, rd_diff[31:0]} < SPAN);
    assign wr_in_range = ~wr_diff[32] & ({1'b0, wr_diff[31:0]} < SPAN);
    assign rd_idx      = rd_diff[AW+1:2];
    assign wr_idx      = wr_diff[AW+1:2];

    always_ff @(posedge clk) begin
        if (prog_we_i && wr_in_range) begin
            mem[wr_idx] <= prog_wdata_i;
        end
    end

    assign can_accept  = (outstanding < MAX_OUT) | instr_rvalid_o;
    assign instr_gnt_o = gnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (instr_req_i) begin
                    if (GNT_WAIT == 0) begin
                        gnt     = can_accept & ~prog_we_i;
                        state_d = S_READY;
                    end else begin
                        cnt_d   = GW_M1;
                        state_d = (GNT_WAIT == 1) ? S_READY : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!instr_req_i) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = S_READY;
                    end
                end
            end
            S_READY: begin
                if (!instr_req_i) begin
                    state_d = S_IDLE;
                end else begin
                    gnt = can_accept & ~prog_we_i;
                    if (gnt && (GNT_WAIT != 0)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A program write owns the single store port and freezes the grant sequencing
        if (prog_we_i) begin
            state_d = state_q;
            cnt_d   = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outstanding <= '0;
        end else begin
            case ({gnt, instr_rvalid_o})
                2'b10:   outstanding <= outstanding + 3'd1;
                2'b01:   outstanding <= outstanding - 3'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Each stage only reloads data when a valid enters it, so the outputs hold between responses
    logic [RESP_LAT-1:0] pv;
    logic [RESP_LAT-1:0] pe;
    logic [31:0]         pd [RESP_LAT];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pv[0] <= 1'b0;
            pe[0] <= 1'b0;
            pd[0] <= '0;
        end else begin
            pv[0] <= gnt;
            if (gnt) begin
                pe[0] <= ~rd_in_range;
                pd[0] <= rd_in_range ? mem[rd_idx] : 32'h0;
            end
        end
    end

    for (genvar i = 1; i < RESP_LAT; i++) begin : g_stage
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                pv[i] <= 1'b0;
                pe[i] <= 1'b0;
                pd[i] <= '0;
            end else begin
                pv[i] <= pv[i-1];
                if (pv[i-1]) begin
                    pe[i] <= pe[i-1];
                    pd[i] <= pd[i-1];
                end
            end
        end
    end

    assign instr_rvalid_o = pv[RESP_LAT-1];
    assign instr_err_o    = pe[RESP_LAT-1];
    assign instr_rdata_o  = pd[RESP_LAT-1];

endmodule

// File: tb/tb_instr_mem_port.sv
// Directed bench for instr_mem_port: three instances cover zero-wait/short-latency,
// grant wait states, and outstanding-limit/reset-flush behaviour.
module tb_instr_mem_port;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req      [3];
    logic [31:0] addr     [3];
    logic        gnt      [3];
    logic        rvalid   [3];
    logic [31:0] rdata    [3];
    logic        err      [3];
    logic        prog_we  [3];
    logic [31:0] prog_addr[3];
    logic [31:0] prog_data[3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // a: depth 16, no wait, latency 1
    instr_mem_port #(.MEM_DEPTH(16), .BASE_ADDR(32'h0), .GNT_WAIT(0), .RESP_LAT(1), .MAX_OUTSTANDING(2)) u_a (
        .clk(clk), .rstn(rstn),
        .instr_req_i(req[0]), .instr_addr_i(addr[0]), .instr_gnt_o(gnt[0]),
        .instr_rvalid_o(rvalid[0]), .instr_rdata_o(rdata[0]), .instr_err_o(err[0]),
        .prog_we_i(prog_we[0]), .prog_addr_i(prog_addr[0]), .prog_wdata_i(prog_data[0]));

    instr_mem_port #(.GNT_WAIT(2), .RESP_LAT(1), .MAX_OUTSTANDING(2)) u_b (
        .clk(clk), .rstn(rstn),
        .instr_req_i(req[1]), .instr_addr_i(addr[1]), .instr_gnt_o(gnt[1]),
        .instr_rvalid_o(rvalid[1]), .instr_rdata_o(rdata[1]), .instr_err_o(err[1]),
        .prog_we_i(prog_we[1]), .prog_addr_i(prog_addr[1]), .prog_wdata_i(prog_data[1]));

    instr_mem_port #(.GNT_WAIT(0), .RESP_LAT(3), .MAX_OUTSTANDING(2)) u_c (
        .clk(clk), .rstn(rstn),
        .instr_req_i(req[2]), .instr_addr_i(addr[2]), .instr_gnt_o(gnt[2]),
        .instr_rvalid_o(rvalid[2]), .instr_rdata_o(rdata[2]), .instr_err_o(err[2]),
        .prog_we_i(prog_we[2]), .prog_addr_i(prog_addr[2]), .prog_wdata_i(prog_data[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic prog_a(input logic [31:0] a, input logic [31:0] d);
        next_cycle();
        prog_we[0]   = 1'b1;
        prog_addr[0] = a;
        prog_data[0] = d;
    endtask

    int exp_gnt_c [7] = '{1, 1, 0, 1, 1, 0, 1};
    int exp_rv_c  [7] = '{0, 0, 0, 1, 1, 0, 1};
    int exp_out_c [7] = '{0, 1, 2, 2, 2, 2, 2};

    initial begin
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; addr[i] = '0;
            prog_we[i] = 1'b0; prog_addr[i] = '0; prog_data[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_gnt%0d", i), {31'b0, gnt[i]}, 32'd0);
            check($sformatf("rst_rvalid%0d", i), {31'b0, rvalid[i]}, 32'd0);
            check($sformatf("rst_rdata%0d", i), rdata[i], 32'd0);
            check($sformatf("rst_err%0d", i), {31'b0, err[i]}, 32'd0);
        end
        rstn = 1'b1;

        // preload; the write to 0x40 is out of range and must not alias onto word 0
        prog_a(32'h0000_0000, 32'h0000_0013);
        prog_a(32'h0000_0004, 32'h0040_0093);
        prog_a(32'h0000_000C, 32'hDEAD_0003);
        prog_a(32'h0000_003C, 32'hCAFE_F00D);
        prog_a(32'h0000_0040, 32'hBAD0_BAD0);

        next_cycle(); prog_we[0] = 1'b0; req[0] = 1'b1; addr[0] = 32'h0;
        @(negedge clk);
        check("a_c0_gnt", {31'b0, gnt[0]}, 32'd1);
        check("a_c0_rvalid", {31'b0, rvalid[0]}, 32'd0);
        next_cycle(); addr[0] = 32'h4;
        @(negedge clk);
        check("a_c1_gnt", {31'b0, gnt[0]}, 32'd1);
        check("a_c1_rvalid", {31'b0, rvalid[0]}, 32'd1);
        check("a_c1_rdata", rdata[0], 32'h0000_0013);
        check("a_c1_err", {31'b0, err[0]}, 32'd0);
        next_cycle(); req[0] = 1'b0;
        @(negedge clk);
        check("a_c2_gnt", {31'b0, gnt[0]}, 32'd0);
        check("a_c2_rvalid", {31'b0, rvalid[0]}, 32'd1);
        check("a_c2_rdata", rdata[0], 32'h0040_0093);
        next_cycle(); req[0] = 1'b1; addr[0] = 32'h40;
        @(negedge clk);
        check("a_oor_gnt", {31'b0, gnt[0]}, 32'd1);
        check("a_hold_rvalid", {31'b0, rvalid[0]}, 32'd0);
        check("a_hold_rdata", rdata[0], 32'h0040_0093);
        next_cycle(); addr[0] = 32'h3E;
        @(negedge clk);
        check("a_oor_rvalid", {31'b0, rvalid[0]}, 32'd1);
        check("a_oor_err", {31'b0, err[0]}, 32'd1);
        check("a_oor_rdata", rdata[0], 32'd0);
        next_cycle(); req[0] = 1'b0;
        @(negedge clk);
        check("a_w15_rvalid", {31'b0, rvalid[0]}, 32'd1);
        check("a_w15_err", {31'b0, err[0]}, 32'd0);
        check("a_w15_rdata", rdata[0], 32'hCAFE_F00D);
        next_cycle();
        req[0] = 1'b1; addr[0] = 32'hC;
        prog_we[0] = 1'b1; prog_addr[0] = 32'hC; prog_data[0] = 32'h1234_5678;
        @(negedge clk);
        check("a_we_gnt", {31'b0, gnt[0]}, 32'd0);
        next_cycle(); prog_we[0] = 1'b0;
        @(negedge clk);
        check("a_after_we_gnt", {31'b0, gnt[0]}, 32'd1);
        next_cycle(); req[0] = 1'b0;
        @(negedge clk);
        check("a_raw_rvalid", {31'b0, rvalid[0]}, 32'd1);
        check("a_raw_rdata", rdata[0], 32'h1234_5678);

        // b: two grant wait states
        next_cycle(); req[1] = 1'b1; addr[1] = 32'h0;
        @(negedge clk); check("b_c0_gnt", {31'b0, gnt[1]}, 32'd0);
        next_cycle();
        @(negedge clk); check("b_c1_gnt", {31'b0, gnt[1]}, 32'd0);
        next_cycle();
        @(negedge clk); check("b_c2_gnt", {31'b0, gnt[1]}, 32'd1);
        next_cycle(); req[1] = 1'b0;
        @(negedge clk);
        check("b_c3_gnt", {31'b0, gnt[1]}, 32'd0);
        check("b_c3_rvalid", {31'b0, rvalid[1]}, 32'd1);
        check("b_c3_err", {31'b0, err[1]}, 32'd0);
        repeat (2) next_cycle();
        req[1] = 1'b1;
        @(negedge clk); check("b_r0_gnt", {31'b0, gnt[1]}, 32'd0);
        next_cycle(); req[1] = 1'b0;
        @(negedge clk); check("b_r1_gnt", {31'b0, gnt[1]}, 32'd0);
        next_cycle(); req[1] = 1'b1;
        @(negedge clk); check("b_r2_gnt", {31'b0, gnt[1]}, 32'd0);
        next_cycle();
        @(negedge clk); check("b_r3_gnt", {31'b0, gnt[1]}, 32'd0);
        next_cycle();
        @(negedge clk); check("b_r4_gnt", {31'b0, gnt[1]}, 32'd1);
        next_cycle(); req[1] = 1'b0;
        @(negedge clk); check("b_r5_rvalid", {31'b0, rvalid[1]}, 32'd1);

        // c: latency 3 against two outstanding slots, req held
        for (int k = 0; k < 7; k++) begin
            next_cycle();
            req[2] = 1'b1; addr[2] = 32'h10;
            @(negedge clk);
            check($sformatf("c_gnt_c%0d", k), {31'b0, gnt[2]}, 32'(exp_gnt_c[k]));
            check($sformatf("c_rvalid_c%0d", k), {31'b0, rvalid[2]}, 32'(exp_rv_c[k]));
            check($sformatf("c_out_c%0d", k), {29'b0, u_c.outstanding}, 32'(exp_out_c[k]));
        end
        next_cycle(); req[2] = 1'b0;
        repeat (5) next_cycle();
        @(negedge clk);
        check("c_drained_out", {29'b0, u_c.outstanding}, 32'd0);

        // reset while a response is in flight
        next_cycle(); req[2] = 1'b1;
        @(negedge clk); check("c_rst_gnt", {31'b0, gnt[2]}, 32'd1);
        next_cycle(); req[2] = 1'b0; rstn = 1'b0;
        @(negedge clk);
        check("c_in_rst_rvalid", {31'b0, rvalid[2]}, 32'd0);
        check("c_in_rst_out", {29'b0, u_c.outstanding}, 32'd0);
        next_cycle(); rstn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("c_post_rst_rvalid%0d", k), {31'b0, rvalid[2]}, 32'd0);
            next_cycle();
        end
        @(negedge clk);
        check("c_post_rst_out", {29'b0, u_c.outstanding}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
